proc_param: RTL and testbench

PROC_PARAM -- requirements
Module: proc_param

---
 rtl/proc_pkg.sv | 16 +
 rtl/proc_alu.sv | 18 +
 rtl/proc_param.sv | 97 +++++++++
 tb/tb_proc_param.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, FSM state encoding and bus-select encoding shared by the processor.
package proc_pkg;
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  typedef enum logic [1:0] {SEL_REG, SEL_DIN, SEL_G, SEL_ZERO} bus_sel_t;
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;
  function automatic logic is_alu(input logic [2:0] op);
    return op inside {[OP_ADD:OP_XOR]};
  endfunction
endpackage

// File: rtl/proc_alu.sv
// proc_alu: combinational A op B for the ALU opcodes; wraps modulo 2^DATA_W.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  always_comb
    y = op == OP_ADD ? a + b :
        op == OP_SUB ? a - b :
        op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_XOR ? a ^ b : b;
endmodule

// File: rtl/proc_param.sv
// proc_param: multi-cycle bus processor with NREG registers, A/G ALU latches and a T0..T3 FSM.
module proc_param
  import proc_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int NREG   = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires
);
  localparam int RW = $clog2(NREG);
  state_t state, state_nx;
  bus_sel_t sel;
  logic [RW-1:0] sel_idx, rx, ry;
  logic [2:0] op;
  logic [DATA_W-1:0] r [NREG];
  logic [DATA_W-1:0] a, g, alu_y;
  logic r_we, a_we, g_we;

  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) state <= T0;
    else state <= state_nx;

  // Only the opcode and register fields of the instruction word are kept.
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) {op, rx, ry} <= '0;
    else if (state == T0 && Run) {op, rx, ry} <= {DIN[DATA_W-1 -: 3], DIN[2*RW-1:RW], DIN[RW-1:0]};

  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      for (int i = 0; i < NREG; i++) r[i] <= '0;
      a <= '0;
      g <= '0;
    end else begin
      if (r_we) r[rx] <= BusWires;
      if (a_we) a <= BusWires;
      if (g_we) g <= alu_y;
    end

  always_comb
    state_nx = state == T0 ? (Run ? T1 : T0) :
               state == T1 ? (is_alu(op) ? T2 : T0) :
               state == T2 ? T3 : T0;

  always_comb begin
    sel = SEL_ZERO;
    sel_idx = ry;
    r_we = 1'b0;
    a_we = 1'b0;
    g_we = 1'b0;
    Done = 1'b0;
    case (state)
      T1:
        if (is_alu(op)) begin
          sel = SEL_REG;
          sel_idx = rx;
          a_we = 1'b1;
        end else if (op == OP_MVI) begin
          sel = SEL_DIN;
          r_we = 1'b1;
          Done = 1'b1;
        end else begin
          Done = 1'b1;
          if (op == OP_MV || g != '0) begin
            sel = SEL_REG;
            r_we = 1'b1;
          end
        end
      T2: begin
        sel = SEL_REG;
        g_we = 1'b1;
      end
      T3: begin
        sel = SEL_G;
        r_we = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb
    BusWires = sel == SEL_REG ? r[sel_idx] :
               sel == SEL_DIN ? DIN :
               sel == SEL_G   ? g : '0;

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op(op),
    .a (a),
    .b (BusWires),
    .y (alu_y)
  );
endmodule

// File: tb/tb_proc_param.sv
// tb_proc_param: directed vector table plus reset-abort and back-to-back sequences for proc_param.
module tb_proc_param;
  import proc_pkg::*;
  logic Clock = 1'b0, Resetn = 1'b0, Run = 1'b0, Done;
  logic [8:0] DIN = '0, BusWires;
  logic Run16 = 1'b0, Done16;
  logic [15:0] DIN16 = '0, Bus16;
  int n_cmp = 0, n_bad = 0;

  proc_param dut (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Run(Run), .Done(Done), .BusWires(BusWires)
  );
  proc_param #(.DATA_W(16), .NREG(16)) dut16 (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN16), .Run(Run16), .Done(Done16), .BusWires(Bus16)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string      name;
    logic [8:0] ins;
    logic [8:0] imm;
    logic [8:0] bus;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    return {op, x, y};
  endfunction

  function automatic logic [15:0] enc16(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    return {op, 5'b0, x, y};
  endfunction

  // Fetch one instruction from idle, then wait (bounded) for Done and capture the bus.
  task automatic exec(input logic [8:0] ins, input logic [8:0] imm, output logic [8:0] bus, output int lat);
    @(negedge Clock);
    check("idle_t0", 32'({Done, BusWires}), 32'd0);
    DIN = ins;
    Run = 1'b1;
    @(posedge Clock);
    #1;
    DIN = imm;
    Run = 1'b0;
    lat = -1;
    bus = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clock);
      if (Done) begin
        lat = c;
        bus = BusWires;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v[$];
    logic [8:0] bus;
    int lat;
    logic [15:0] d[10], eb[10];
    logic ed[10];
    v.push_back('{"mvi_r0_5",     enc(OP_MVI, 0, 0),  9'h005, 9'h005, 1});
    v.push_back('{"mvi_r1_3",     enc(OP_MVI, 1, 0),  9'h003, 9'h003, 1});
    v.push_back('{"add_r0_r1",    enc(OP_ADD, 0, 1),  9'h1AA, 9'h008, 3});
    v.push_back('{"rd_r0_8",      enc(OP_MV, 0, 0),   9'h1AA, 9'h008, 1});
    v.push_back('{"mvi_r0_2",     enc(OP_MVI, 0, 0),  9'h002, 9'h002, 1});
    v.push_back('{"sub_wrap",     enc(OP_SUB, 0, 1),  9'h1AA, 9'h1FF, 3});
    v.push_back('{"rd_r0_1ff",    enc(OP_MV, 0, 0),   9'h1AA, 9'h1FF, 1});
    v.push_back('{"mvi_r2_f0",    enc(OP_MVI, 2, 0),  9'h0F0, 9'h0F0, 1});
    v.push_back('{"mvi_r3_ff",    enc(OP_MVI, 3, 0),  9'h0FF, 9'h0FF, 1});
    v.push_back('{"and_r2_r3",    enc(OP_AND, 2, 3),  9'h1AA, 9'h0F0, 3});
    v.push_back('{"mvi_r2_f0b",   enc(OP_MVI, 2, 0),  9'h0F0, 9'h0F0, 1});
    v.push_back('{"or_r2_r3",     enc(OP_OR, 2, 3),   9'h1AA, 9'h0FF, 3});
    v.push_back('{"mvi_r2_f0c",   enc(OP_MVI, 2, 0),  9'h0F0, 9'h0F0, 1});
    v.push_back('{"xor_r2_r3",    enc(OP_XOR, 2, 3),  9'h1AA, 9'h00F, 3});
    v.push_back('{"rd_r2_0f",     enc(OP_MV, 2, 2),   9'h1AA, 9'h00F, 1});
    v.push_back('{"xor_r3_r3_g0", enc(OP_XOR, 3, 3),  9'h1AA, 9'h000, 3});
    v.push_back('{"mvi_r4_55",    enc(OP_MVI, 4, 0),  9'h055, 9'h055, 1});
    v.push_back('{"mvnz_g0",      enc(OP_MVNZ, 4, 1), 9'h1AA, 9'h000, 1});
    v.push_back('{"rd_r4_kept",   enc(OP_MV, 4, 4),   9'h1AA, 9'h055, 1});
    v.push_back('{"mvi_r6_4",     enc(OP_MVI, 6, 0),  9'h004, 9'h004, 1});
    v.push_back('{"mvi_r7_3",     enc(OP_MVI, 7, 0),  9'h003, 9'h003, 1});
    v.push_back('{"add_g7",       enc(OP_ADD, 6, 7),  9'h1AA, 9'h007, 3});
    v.push_back('{"mvnz_g7",      enc(OP_MVNZ, 4, 1), 9'h1AA, 9'h003, 1});
    v.push_back('{"rd_r4_r1",     enc(OP_MV, 4, 4),   9'h1AA, 9'h003, 1});
    v.push_back('{"add_r6_r6",    enc(OP_ADD, 6, 6),  9'h1AA, 9'h00E, 3});
    v.push_back('{"rd_r6_e",      enc(OP_MV, 6, 6),   9'h1AA, 9'h00E, 1});
    v.push_back('{"mv_r5_r0",     enc(OP_MV, 5, 0),   9'h1AA, 9'h1FF, 1});
    v.push_back('{"rd_r5",        enc(OP_MV, 5, 5),   9'h1AA, 9'h1FF, 1});

    #1;
    check("reset_done", 32'(Done), 32'd0);
    check("reset_bus", 32'(BusWires), 32'd0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;

    foreach (v[i]) begin
      exec(v[i].ins, v[i].imm, bus, lat);
      check({v[i].name, "_bus"}, 32'(bus), 32'(v[i].bus));
      check({v[i].name, "_lat"}, 32'(lat), 32'(v[i].lat));
    end

    // Asynchronous reset during T2 of an ADD aborts it with no register write.
    exec(enc(OP_MVI, 0, 0), 9'h005, bus, lat);
    check("pre_rst_mvi", 32'(bus), 32'h005);
    @(negedge Clock);
    DIN = enc(OP_ADD, 0, 0);
    Run = 1'b1;
    @(posedge Clock);
    #1;
    Run = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("t2_bus_ry", 32'(BusWires), 32'h005);
    #1 Resetn = 1'b0;
    #1;
    check("async_rst_done", 32'(Done), 32'd0);
    check("async_rst_bus", 32'(BusWires), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    exec(enc(OP_MV, 0, 0), 9'h1AA, bus, lat);
    check("rst_r0_zero", 32'(bus), 32'd0);
    exec(enc(OP_MV, 1, 1), 9'h1AA, bus, lat);
    check("rst_r1_zero", 32'(bus), 32'd0);
    exec(enc(OP_MVI, 0, 0), 9'h001, bus, lat);
    check("post_rst_mvi_bus", 32'(bus), 32'h001);
    check("post_rst_mvi_lat", 32'(lat), 32'd1);
    exec(enc(OP_MV, 0, 0), 9'h1AA, bus, lat);
    check("post_rst_r0", 32'(bus), 32'h001);

    // Back-to-back on the 16-bit/16-register instance with Run held high.
    d  = '{enc16(OP_MVI, 15, 0), 16'h1234, enc16(OP_MV, 14, 15), 16'hFFFF, enc16(OP_ADD, 15, 14),
           16'hFFFF, 16'hFFFF, 16'hFFFF, enc16(OP_MV, 1, 15), 16'hFFFF};
    eb = '{16'h0, 16'h1234, 16'h0, 16'h1234, 16'h0, 16'h1234, 16'h1234, 16'h2468, 16'h0, 16'h2468};
    ed = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      DIN16 = d[i];
      Run16 = 1'b1;
      #1;
      check($sformatf("b2b_bus_%0d", i), 32'(Bus16), 32'(eb[i]));
      check($sformatf("b2b_done_%0d", i), 32'(Done16), 32'(ed[i]));
    end
    @(negedge Clock);
    Run16 = 1'b0;
    #1;
    check("b2b_end_idle", 32'({Done16, Bus16}), 32'd0);
    @(negedge Clock);
    check("b2b_stays_idle", 32'({Done16, Bus16}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
